// File: rtl/skin_ellipse_classify_pkg.sv
// Shared constants, stage tag type and fixed-point helpers for the skin-cluster ellipse test.
// Default ellipse constants are common with the transcb/transcr stages.
package skin_ellipse_classify_pkg;

    localparam int CX     = 109;
    localparam int CY     = 152;
    localparam int COS_Q8 = -209;
    localparam int SIN_Q8 = 147;
    localparam int ECX    = 2;
    localparam int ECY    = 2;
    localparam int INV_A2 = 102;
    localparam int INV_B2 = 333;

    localparam int LATENCY  = 5;
    localparam int DIFF_W   = 9;
    localparam int PROD_W   = 18;
    localparam int SUM_W    = 19;
    localparam int COORD_W  = 10;
    localparam int SQ_W     = 20;
    localparam int ACC_W    = 32;

    localparam logic [ACC_W-1:0] UNIT_Q16 = 32'd65536;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } pix_tag_t;

    // Q8 rotation result back to integer (floor toward -inf), then apply the post-rotation offset.
    function automatic logic signed [COORD_W-1:0] shift_off(
        input logic signed [SUM_W-1:0] sum,
        input int                      off
    );
        logic signed [SUM_W-1:0] sh;
        sh = sum >>> 8;
        sh = sh - SUM_W'(off);
        return sh[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/skin_ellipse_math.sv
// Five-stage ellipse membership datapath: centre, rotate, offset, square, weighted sum and compare.
// Frame markers ride alongside each pixel in a tag shift register of matching depth.
module skin_ellipse_math
    import skin_ellipse_classify_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] transcb_i,
    input  logic [7:0] transcr_i,
    input  logic       valid_i,
    input  logic       sof_i,
    input  logic       eof_i,
    output logic       skin_o,
    output logic       valid_o,
    output logic       sof_o,
    output logic       eof_o
);

    localparam logic signed [DIFF_W-1:0] CX_S   = DIFF_W'(CX);
    localparam logic signed [DIFF_W-1:0] CY_S   = DIFF_W'(CY);
    localparam logic signed [PROD_W-1:0] COS_S  = PROD_W'(COS_Q8);
    localparam logic signed [PROD_W-1:0] SIN_S  = PROD_W'(SIN_Q8);
    localparam logic [ACC_W-1:0]         INV_A2_U = ACC_W'(INV_A2);
    localparam logic [ACC_W-1:0]         INV_B2_U = ACC_W'(INV_B2);

    pix_tag_t tag_q [0:LATENCY-1];

    logic signed [DIFF_W-1:0]  dcb_q, dcb_d, dcr_q, dcr_d;
    logic signed [PROD_W-1:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic signed [SUM_W-1:0]   sum_x, sum_y;
    logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [SQ_W-1:0]    xs, ys;
    logic [SQ_W-1:0]           x2_q, x2_d, y2_q, y2_d;
    logic [ACC_W-1:0]          acc;
    logic                      skin_q, skin_d;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_q[gi] <= '0;
                end else if (gi == 0) begin
                    tag_q[gi] <= '{valid: valid_i, sof: sof_i, eof: eof_i};
                end else begin
                    tag_q[gi] <= tag_q[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        dcb_d = $signed({1'b0, transcb_i}) - CX_S;
        dcr_d = $signed({1'b0, transcr_i}) - CY_S;

        p0_d = COS_S * PROD_W'(dcb_q);
        p1_d = SIN_S * PROD_W'(dcr_q);
        p2_d = SIN_S * PROD_W'(dcb_q);
        p3_d = COS_S * PROD_W'(dcr_q);

        sum_x = SUM_W'(p0_q) + SUM_W'(p1_q);
        sum_y = SUM_W'(p3_q) - SUM_W'(p2_q);
        x_d   = shift_off(sum_x, ECX);
        y_d   = shift_off(sum_y, ECY);

        xs   = SQ_W'(x_q);
        ys   = SQ_W'(y_q);
        x2_d = xs * xs;
        y2_d = ys * ys;

        // Ellipse boundary itself counts as inside.
        acc    = {12'd0, x2_q} * INV_A2_U + {12'd0, y2_q} * INV_B2_U;
        skin_d = tag_q[3].valid && (acc <= UNIT_Q16);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcb_q  <= '0;
            dcr_q  <= '0;
            p0_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            x2_q   <= '0;
            y2_q   <= '0;
            skin_q <= 1'b0;
        end else begin
            dcb_q  <= dcb_d;
            dcr_q  <= dcr_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            p3_q   <= p3_d;
            x_q    <= x_d;
            y_q    <= y_d;
            x2_q   <= x2_d;
            y2_q   <= y2_d;
            skin_q <= skin_d;
        end
    end

    assign skin_o  = skin_q;
    assign valid_o = tag_q[LATENCY-1].valid;
    assign sof_o   = tag_q[LATENCY-1].sof;
    assign eof_o   = tag_q[LATENCY-1].eof;

endmodule

// File: rtl/skin_ellipse_classify.sv
// Skin classifier top: ellipse datapath plus a saturating per-frame skin-pixel counter.
// The frame count and done pulse land one clock after the eof pixel's decision.
module skin_ellipse_classify
    import skin_ellipse_classify_pkg::*;
#(
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         transcb,
    input  logic [7:0]         transcr,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_eof,
    output logic               skin,
    output logic               skin_valid,
    output logic [COUNT_W-1:0] frame_skin_count,
    output logic               frame_done
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               m_skin, m_valid, m_sof, m_eof;
    logic [COUNT_W-1:0] run_q, run_d, base;
    logic [COUNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;

    skin_ellipse_math u_math (
        .clk       (clk),
        .rst       (rst),
        .transcb_i (transcb),
        .transcr_i (transcr),
        .valid_i   (in_valid),
        .sof_i     (in_sof),
        .eof_i     (in_eof),
        .skin_o    (m_skin),
        .valid_o   (m_valid),
        .sof_o     (m_sof),
        .eof_o     (m_eof)
    );

    // sof restarts the run, discarding any partial frame without a done pulse.
    always_comb begin
        run_d        = run_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        base         = m_sof ? '0 : run_q;
        if (m_valid) begin
            if (m_skin && (base != CNT_MAX)) begin
                run_d = base + COUNT_W'(1);
            end else begin
                run_d = base;
            end
            if (m_eof) begin
                frame_cnt_d  = run_d;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            run_q        <= run_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign skin             = m_skin;
    assign skin_valid       = m_valid;
    assign frame_skin_count = frame_cnt_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_skin_ellipse_classify.sv
// Scoreboard bench for skin_ellipse_classify: a 20-bit and a 4-bit counter instance share one stream.
module tb_skin_ellipse_classify;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  transcb = '0;
    logic [7:0]  transcr = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;

    logic        skin, skin_valid, frame_done;
    logic [19:0] fcount;
    logic        skin4, sv4, fd4;
    logic [3:0]  fcount4;

    skin_ellipse_classify #(.COUNT_W(20)) dut (
        .clk(clk), .rst(rst), .transcb(transcb), .transcr(transcr),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .skin(skin), .skin_valid(skin_valid),
        .frame_skin_count(fcount), .frame_done(frame_done)
    );

    skin_ellipse_classify #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .transcb(transcb), .transcr(transcr),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .skin(skin4), .skin_valid(sv4),
        .frame_skin_count(fcount4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int issue;
        bit skin;
        bit eof;
        int cnt20;
        int cnt4;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   run20 = 0;
    int   run4 = 0;
    bit   pend = 0;
    int   pend20 = 0;
    int   pend4 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor256(input int a);
        if (a >= 0) return a / 256;
        return -((-a + 255) / 256);
    endfunction

    function automatic bit ref_skin(input int cb, input int cr);
        int dcb, dcr, x, y, acc;
        dcb = cb - 109;
        dcr = cr - 152;
        x   = floor256(-209 * dcb + 147 * dcr) - 2;
        y   = floor256(-209 * dcr - 147 * dcb) - 2;
        acc = x * x * 102 + y * y * 333;
        return acc <= 65536;
    endfunction

    // exp_skin < 0 means take the reference model; exp_frame < 0 means take the running model count.
    task automatic send(input int cb, input int cr, input bit sof, input bit eof,
                        input int exp_skin, input int exp_frame);
        exp_t e;
        bit   sk;
        @(posedge clk); #1;
        transcb  = 8'(cb);
        transcr  = 8'(cr);
        in_valid = 1'b1;
        in_sof   = sof;
        in_eof   = eof;
        sk = (exp_skin < 0) ? ref_skin(cb, cr) : (exp_skin != 0);
        run20 = sof ? int'(sk) : ((run20 < 1048575) ? run20 + int'(sk) : run20);
        run4  = sof ? int'(sk) : ((run4 < 15) ? run4 + int'(sk) : run4);
        e.issue = cyc;
        e.skin  = sk;
        e.eof   = eof;
        e.cnt20 = (exp_frame >= 0) ? exp_frame : run20;
        e.cnt4  = (exp_frame >= 0) ? ((exp_frame > 15) ? 15 : exp_frame) : run4;
        sb_q.push_back(e);
        $display("send cb=%0d cr=%0d sof=%0b eof=%0b exp_skin=%0b", cb, cr, sof, eof, sk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_eof   = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        sb_q.delete();
        pend  = 0;
        run20 = 0;
        run4  = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every skin_valid and checks the frame pulse that must follow eof.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pend) begin
                    check("frame_done", frame_done, 1);
                    check("frame_done_w4", fd4, 1);
                    check("frame_count", fcount, pend20);
                    check("frame_count_w4", fcount4, pend4);
                    $display("frame count=%0d count_w4=%0d", fcount, fcount4);
                    pend = 0;
                end else if (frame_done || fd4) begin
                    check("unexpected_frame_done", {frame_done, fd4}, 0);
                end
                if (skin_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_skin_valid", skin_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("skin", skin, e.skin);
                        check("skin_w4", skin4, e.skin);
                        check("latency", cyc - e.issue, 5);
                        $display("recv skin=%0b exp=%0b lat=%0d", skin, e.skin, cyc - e.issue);
                        if (e.eof) begin
                            pend   = 1;
                            pend20 = e.cnt20;
                            pend4  = e.cnt4;
                        end
                    end
                end else if (sb_q.size() > 0 && (cyc - sb_q[0].issue) >= 5) begin
                    check("skin_valid_timeout", skin_valid, 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(2);
        check("reset_skin", skin, 0);
        check("reset_skin_valid", skin_valid, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_count", fcount, 0);
        check("reset_count_w4", fcount4, 0);

        // Centre pixel and far pixel, then a back-to-back alternating stream.
        send(109, 152, 0, 0, 1, -1);
        idle(8);
        send(0, 0, 0, 0, 0, -1);
        idle(8);
        send(109, 152, 0, 0, 1, -1);
        send(0, 0, 0, 0, 0, -1);
        send(109, 152, 0, 0, 1, -1);
        send(0, 0, 0, 0, 0, -1);
        idle(8);

        // Frame with a bubble inside: 3 skin pixels.
        send(109, 152, 1, 0, 1, -1);
        send(109, 152, 0, 0, 1, -1);
        idle(1);
        send(0, 0, 0, 0, 0, -1);
        send(109, 152, 0, 1, 1, 3);
        idle(8);

        // One-pixel frame.
        send(109, 152, 1, 1, 1, 1);
        idle(8);

        // Reset two clocks after a sof pixel, then a clean frame.
        send(109, 152, 1, 0, 1, -1);
        idle(1);
        do_reset(1);
        idle(8);
        check("count_after_reset", fcount, 0);
        send(109, 152, 1, 0, 1, -1);
        send(0, 0, 0, 0, 0, -1);
        send(109, 152, 0, 1, 1, 2);
        idle(8);

        // Mid-frame sof discards the partial frame; eof without sof continues the run.
        send(109, 152, 1, 0, 1, -1);
        send(109, 152, 0, 0, 1, -1);
        send(0, 0, 1, 0, 0, -1);
        send(109, 152, 0, 0, 1, -1);
        send(109, 152, 0, 1, 1, 2);
        idle(3);
        send(109, 152, 0, 1, 1, 3);
        idle(8);

        // 20 skin pixels: 20-bit counter gives 20, 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            send(109, 152, i == 0, i == 19, 1, 20);
        end
        idle(8);

        // Random sweep against the reference model, one frame with random bubbles.
        for (int i = 0; i < 1500; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 i == 0, i == 1499, -1, -1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(10);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
